// File: rtl/br_pkg.sv
// Shared definitions for the branch predict unit: condition codes,
// clear FSM states and the saturating counter step.
package br_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // One step of a saturating counter held in 32 bits; callers narrow the result.
  function automatic int unsigned sat_step(input int unsigned ctr,
                                           input logic        up,
                                           input int unsigned max_val);
    if (up) begin
      return (ctr >= max_val) ? max_val : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode from ALU flags and func3.
// Reserved codes (010/011) resolve not-taken and report legal = 0.
module branch_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       cf,
  input  logic       zf,
  input  logic       vf,
  input  logic       sf,
  output logic       taken,
  output logic       legal
);

  // Decode every func3 value so no latch can form.
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (func3)
      BEQ:     taken = zf;
      BNE:     taken = ~zf;
      BLT:     taken = sf ^ vf;
      BGE:     taken = ~(sf ^ vf);
      BLTU:    taken = ~cf;
      BGEU:    taken = cf;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: resolves EX branches, trains a PC-indexed
// table of saturating counters, predicts for IF and counts branches and
// mispredicts. The table can be reset to INIT_CTR in the background.
//
//   state | meaning
//   IDLE  | normal operation, predictions and table training enabled
//   CLEAR | one entry per cycle written to INIT_CTR, predictions forced 0
module branch_predict_unit
  import br_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32,
  parameter int CTR_BITS   = 2,
  parameter int INIT_CTR   = 1,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_pred_taken,
  input  logic                  ex_valid,
  input  logic                  ex_branch,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic [2:0]            ex_func3,
  input  logic                  ex_cf,
  input  logic                  ex_zf,
  input  logic                  ex_vf,
  input  logic                  ex_sf,
  input  logic                  ex_pred_taken,
  output logic                  ex_taken,
  output logic                  ex_mispredict,
  output logic                  ex_illegal,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic [PERF_WIDTH-1:0] perf_branches,
  output logic [PERF_WIDTH-1:0] perf_mispredicts
);

  localparam int                  ENTRIES  = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);
  localparam int unsigned         CTR_MAX  = 32'((1 << CTR_BITS) - 1);

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic                  cond_taken;
  logic                  cond_legal;
  logic                  br;
  logic                  resolve;
  logic [CTR_BITS-1:0]   ctr_next;

  clr_state_e            state_q, state_d;
  logic [INDEX_BITS-1:0] clr_ptr_q, clr_ptr_d;
  logic [CTR_BITS-1:0]   bht_q [ENTRIES];
  logic [CTR_BITS-1:0]   bht_d [ENTRIES];
  logic [PERF_WIDTH-1:0] perf_br_q, perf_br_d;
  logic [PERF_WIDTH-1:0] perf_mis_q, perf_mis_d;

  // PC bits outside the index field are deliberately ignored (aliasing allowed).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_WIDTH-1:INDEX_BITS+2], if_pc[1:0],
                            ex_pc[PC_WIDTH-1:INDEX_BITS+2], ex_pc[1:0]};

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];

  branch_cond_eval u_cond (
    .func3 (ex_func3),
    .cf    (ex_cf),
    .zf    (ex_zf),
    .vf    (ex_vf),
    .sf    (ex_sf),
    .taken (cond_taken),
    .legal (cond_legal)
  );

  assign br            = ex_valid & ex_branch;
  assign resolve       = br & cond_legal;
  assign ex_taken      = br & cond_taken;
  assign ex_illegal    = br & ~cond_legal;
  assign ex_mispredict = resolve & (ex_taken != ex_pred_taken);

  assign if_pred_taken    = (state_q == IDLE) & bht_q[if_idx][CTR_BITS-1];
  assign clr_busy         = (state_q == CLEAR);
  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;

  assign ctr_next = CTR_BITS'(sat_step(32'(bht_q[ex_idx]), ex_taken, CTR_MAX));

  // Clear FSM: walk the pointer from 0 to all-ones, then return to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Table next state: train in IDLE, overwrite the pointed entry in CLEAR.
  always_comb begin
    bht_d = bht_q;
    if (state_q == CLEAR) begin
      bht_d[clr_ptr_q] = CTR_INIT;
    end else if (resolve) begin
      bht_d[ex_idx] = ctr_next;
    end
  end

  // Perf counters keep counting during a clear; they wrap naturally.
  always_comb begin
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    if (resolve) begin
      perf_br_d = perf_br_q + PERF_WIDTH'(1);
      if (ex_mispredict) perf_mis_d = perf_mis_q + PERF_WIDTH'(1);
    end
  end

  // State, table and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      perf_br_q  <= '0;
      perf_mis_q <= '0;
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CTR_INIT;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
      bht_q      <= bht_d;
    end
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch condition decoder.
- Resolves conditional branches in EX from the ALU flags and func3, using the same condition encoding.
- Keeps a bimodal branch history table (BHT) of saturating counters, indexed by PC, to give IF a taken/not-taken prediction.
- Flags EX mispredictions and keeps branch and mispredict performance counters; the table can be cleared in the background.

Parameters:
- INDEX_BITS, 6, log2 of BHT entries; index = pc[INDEX_BITS+1:2]
- PC_WIDTH, 32, width of the PC inputs
- CTR_BITS, 2, width of each saturating counter (>=1)
- INIT_CTR, 1, counter value after reset or clear (weakly not taken)
- PERF_WIDTH, 32, width of the performance counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  PC_WIDTH  fetch PC to predict
- if_pred_taken  out  1  MSB of the counter at if_pc index; combinational; 0 while clearing
- ex_valid  in  1  EX slot holds a valid instruction
- ex_branch  in  1  instruction is a conditional branch
- ex_pc  in  PC_WIDTH  PC of the EX instruction
- ex_func3  in  3  branch condition code
- ex_cf, ex_zf, ex_vf, ex_sf  in  1 each  ALU flags
- ex_pred_taken  in  1  prediction made in IF, carried down the pipe
- ex_taken  out  1  resolved outcome; combinational
- ex_mispredict  out  1  resolved outcome differs from ex_pred_taken; combinational
- ex_illegal  out  1  branch with reserved func3 (010/011)
- clr_req  in  1  request a full BHT clear
- clr_busy  out  1  clear in progress
- perf_branches  out  PERF_WIDTH  resolved legal branches
- perf_mispredicts  out  PERF_WIDTH  mispredicted legal branches

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all counters = INIT_CTR; perf counters = 0; FSM = IDLE; clr_busy = 0.
  - Combinational outputs follow their inputs under the reset state.
- Resolve decode, where br = ex_valid & ex_branch:
  - 000 taken = zf; 001 ~zf; 100 sf!=vf; 101 sf==vf; 110 ~cf; 111 cf.
  - 010/011: taken = 0 and ex_illegal = br.
  - Defined for every func3, so no latch. All ex_* outputs are 0 when br = 0.
- ex_mispredict = br & legal & (ex_taken != ex_pred_taken).
- Update, on the clock edge when br & legal & FSM==IDLE:
  - counter at the ex_pc index +1 if taken, saturating at 2^CTR_BITS-1; -1 if not taken, saturating at 0.
  - perf_branches +1.
  - perf_mispredicts +1 if ex_mispredict.
  - Perf counters wrap modulo 2^PERF_WIDTH.
- Illegal branches and non-branches never update the table or the counters.
- Read-during-write (if_pc index == ex_pc index in the same cycle): if_pred_taken shows the pre-update value; the new value is visible next cycle.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req; the clear pointer is set to 0.
  - In CLEAR, one entry per cycle is written to INIT_CTR and the pointer increments. After entry 2^INDEX_BITS-1 is written, go to IDLE. Total 2^INDEX_BITS cycles with clr_busy = 1.
  - clr_req while in CLEAR is ignored, with no restart.
  - In CLEAR: if_pred_taken = 0, table updates are dropped, perf counters are still updated, ex_taken and ex_mispredict stay valid.
  - rst_n asserted mid-clear aborts to IDLE with the full reset state.
- Pointer wrap: the pointer is INDEX_BITS wide; the exit condition is pointer == all-ones, never a width overflow.
- ex_pc and if_pc bits above INDEX_BITS+1 are ignored, so aliasing is allowed.

Decomposition:
- Shared package br_pkg holds:
  - func3 localparams: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - The FSM state enum {IDLE, CLEAR}.
  - The saturating increment/decrement function.
- One natural sub-module, branch_cond_eval: the purely combinational flag/func3 decode with a legal output. The top holds the table, FSM and perf counters.

Test Plan:
- Reset, then if_pc=0x0000_0040 -> if_pred_taken=0 (INIT_CTR=1). perf_branches=0.
- BEQ (func3 000) at ex_pc=0x40, zf=1, ex_pred_taken=0, three cycles -> ex_taken=1 and ex_mispredict=1 each cycle. Counter goes 1->2->3->3 (saturates). if_pred_taken for 0x40 is 1 from the cycle after the first update. perf_branches=3, perf_mispredicts=3.
- Reserved func3=010 with ex_branch=1 -> ex_taken=0, ex_illegal=1, ex_mispredict=0. No counter or table change.
- Update and lookup of the same index in one cycle (index 0x10 at counter 1, taken) -> if_pred_taken=0 that cycle, 1 the next.
- Set index 5 to 3, pulse clr_req -> clr_busy high for exactly 64 cycles; a second clr_req mid-clear is ignored. After clr_busy falls, index 5 predicts 0. A branch resolved during the clear increments perf_branches but leaves the table unchanged.
- Drop rst_n at clear cycle 20 -> clr_busy=0 immediately and every entry = INIT_CTR.
